// File: rtl/parity_frame_ctrl.sv
// Frame parity accumulator: counts len accepted words down to zero, XOR-folds
// every bit into a single parity flag, then holds it until the consumer takes it.
module parity_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             parity,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  // state | meaning
  // IDLE  | waiting for start; len sampled here
  // ACCUM | accepting words, remaining counts down to terminal count 1
  // DONE  | parity presented, held until out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             acc, acc_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [7:0]       frame_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 1'b0;
      remaining <= '0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    frame_cnt_nxt = frame_cnt;
    if (abort) begin
      // abort outranks any beat, start or handshake in the same cycle
      state_nxt     = IDLE;
      acc_nxt       = 1'b0;
      remaining_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_nxt = 1'b0;
            if (len != '0) begin
              remaining_nxt = len;
              state_nxt     = ACCUM;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_nxt       = acc ^ (^in_data);
            remaining_nxt = remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt     = IDLE;
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign parity    = (state == DONE) & acc;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: table of frames plus directed
// corner sequences; expected parity is queued at start and popped at output.
module tb_parity_frame_ctrl;
  localparam int WIDTH = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid, parity, busy;
  logic [7:0]       frame_cnt;

  int         total = 0;
  int         bad = 0;
  logic       exp_q[$];
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    logic [LEN_W-1:0] l;
    logic [31:0]      words;
    logic             par;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  parity_frame_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .parity(parity), .out_ready(out_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic begin_frame(input logic [LEN_W-1:0] l, input logic p);
    start = 1'b1;
    len   = l;
    exp_q.push_back(p);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed(input logic [LEN_W-1:0] l, input logic [31:0] words,
                      input bit gaps, input bit noise);
    int i = 0;
    int guard = 0;
    while (i < int'(l) && guard < 100) begin
      guard++;
      chk("in_ready_accum", in_ready, 1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = words[i*4 +: 4];
        i++;
      end
      start = noise;
      len   = noise ? LEN_W'(5) : '0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    len      = '0;
  endtask

  task automatic consume(input int hold, input bit noise);
    logic pexp;
    chk("out_valid_after_last", out_valid, 1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      pexp = 1'b0;
    end else begin
      pexp = exp_q.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      chk("parity_hold", parity, pexp);
      chk("out_valid_hold", out_valid, 1);
      start = noise;
      len   = noise ? LEN_W'(5) : '0;
      @(negedge clk);
    end
    start = 1'b0;
    len   = '0;
    chk("parity", parity, pexp);
    chk("in_ready_done", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk("idle_after_hs", busy, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic [7:0] cnt_before;

    vecs[0] = '{4'd3, 32'h0000_0F1B, 1'b0};
    vecs[1] = '{4'd2, 32'h0000_0007, 1'b1};
    vecs[2] = '{4'd1, 32'h0000_0001, 1'b1};
    vecs[3] = '{4'd4, 32'h0000_53FF, 1'b0};
    vecs[4] = '{4'd5, 32'h0007_1248, 1'b1};
    vecs[5] = '{4'd8, 32'hFFFF_FFF1, 1'b1};
    vecs[6] = '{4'd0, 32'h0000_0000, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_parity", parity, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      begin_frame(vecs[k].l, vecs[k].par);
      if (vecs[k].l != 0) feed(vecs[k].l, vecs[k].words, k != 0, 1'b0);
      consume($urandom_range(0, 2), 1'b0);
    end

    // stalled input and held output
    begin_frame(4'd2, 1'b1);
    in_valid = 1'b1; in_data = 4'b0111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    consume(5, 1'b0);

    // zero-length frame ignores offered words
    begin_frame(4'd0, 1'b0);
    chk("len0_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    consume(1, 1'b0);

    // abort together with the final beat
    start = 1'b1; len = 4'd2;
    @(negedge clk);
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_data = 4'b0001;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_out_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("abort_frame_cnt", frame_cnt, exp_cnt);

    // asynchronous reset in the middle of ACCUM
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_data = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_parity", parity, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_frame(4'd1, 1'b1);
    feed(4'd1, 32'h1, 1'b0, 1'b0);
    consume(0, 1'b0);

    // 256 single-word frames with stray start pulses: counter wraps
    cnt_before = exp_cnt;
    for (int f = 0; f < 256; f++) begin
      d = 4'($urandom_range(0, 15));
      begin_frame(4'd1, ^d);
      feed(4'd1, {28'd0, d}, 1'b0, 1'b1);
      consume(1, 1'b1);
    end
    chk("cnt_wrap", frame_cnt, cnt_before);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
